// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared widths, iteration count and state encodings for div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

  localparam int c_div_width  = 32;
  localparam int c_iter_count = 32;
  localparam int c_cnt_width  = 6;
  localparam int c_st_width   = 2;

  localparam logic [c_cnt_width-1:0] c_last_iter = c_cnt_width'(c_iter_count - 1);

  localparam logic [c_st_width-1:0] c_st_free    = 2'd0;
  localparam logic [c_st_width-1:0] c_st_by_zero = 2'd1;
  localparam logic [c_st_width-1:0] c_st_on      = 2'd2;
  localparam logic [c_st_width-1:0] c_st_end     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_if
// Description : EX-stage request/result bundle between the pipeline and div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if;
  import div_unit_pkg::*;

  logic                       start_i;
  logic                       annul_i;
  logic                       signed_div_i;
  logic [c_div_width-1:0]     opdata1_i;
  logic [c_div_width-1:0]     opdata2_i;
  logic [2*c_div_width-1:0]   result_o;
  logic                       ready_o;
  logic                       stallreq_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );

endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
  import div_unit_pkg::*;
(
  input  wire        clk,
  input  wire        rst,
  div_unit_if.slave  dif
);

  logic [c_st_width-1:0]    r_state;
  logic [c_st_width-1:0]    w_next_state;
  logic [c_cnt_width-1:0]   r_cnt;
  logic [c_div_width-1:0]   r_dvd_raw;
  logic [c_div_width-1:0]   r_divisor;
  logic [c_div_width-1:0]   r_rem;
  logic [c_div_width-1:0]   r_quo;
  logic                     r_quo_neg;
  logic                     r_rem_neg;
  logic [2*c_div_width-1:0] r_result;

  logic                     w_accept;
  logic                     w_dvd_neg;
  logic                     w_dvs_neg;
  logic [c_div_width-1:0]   w_dvd_abs;
  logic [c_div_width-1:0]   w_dvs_abs;
  logic [c_div_width:0]     w_shift;
  logic [c_div_width:0]     w_diff;
  logic                     w_fits;
  logic [c_div_width-1:0]   w_rem_step;
  logic [c_div_width-1:0]   w_quo_step;
  logic [c_div_width-1:0]   w_rem_fix;
  logic [c_div_width-1:0]   w_quo_fix;
  logic                     w_last;

  assign w_accept  = (r_state == c_st_free) && dif.start_i && !dif.annul_i;
  assign w_dvd_neg = dif.signed_div_i && dif.opdata1_i[c_div_width-1];
  assign w_dvs_neg = dif.signed_div_i && dif.opdata2_i[c_div_width-1];
  assign w_dvd_abs = w_dvd_neg ? -dif.opdata1_i : dif.opdata1_i;
  assign w_dvs_abs = w_dvs_neg ? -dif.opdata2_i : dif.opdata2_i;

  // Quotient bits shift in from the right while dividend bits shift out into the partial remainder.
  assign w_shift    = {r_rem, r_quo[c_div_width-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_fits     = ~w_diff[c_div_width];
  assign w_rem_step = w_fits ? w_diff[c_div_width-1:0] : w_shift[c_div_width-1:0];
  assign w_quo_step = {r_quo[c_div_width-2:0], w_fits};
  assign w_rem_fix  = r_rem_neg ? -w_rem_step : w_rem_step;
  assign w_quo_fix  = r_quo_neg ? -w_quo_step : w_quo_step;
  assign w_last     = (r_cnt == c_last_iter);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_free;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_free: begin
        if (w_accept) begin
          w_next_state = (dif.opdata2_i == '0) ? c_st_by_zero : c_st_on;
        end
      end
      c_st_by_zero: begin
        w_next_state = dif.annul_i ? c_st_free : c_st_end;
      end
      c_st_on: begin
        if (dif.annul_i) begin
          w_next_state = c_st_free;
        end else if (w_last) begin
          w_next_state = c_st_end;
        end
      end
      c_st_end: begin
        if (dif.annul_i || !dif.start_i) begin
          w_next_state = c_st_free;
        end
      end
      default: w_next_state = c_st_free;
    endcase
  end

  always_comb begin
    dif.ready_o    = (r_state == c_st_end);
    dif.result_o   = (r_state == c_st_end) ? r_result : '0;
    dif.stallreq_o = dif.start_i && (r_state != c_st_end) && !dif.annul_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_dvd_raw <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_quo_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        c_st_free: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_dvd_raw <= dif.opdata1_i;
            r_divisor <= w_dvs_abs;
            r_rem     <= '0;
            r_quo     <= w_dvd_abs;
            r_quo_neg <= w_dvd_neg ^ w_dvs_neg;
            r_rem_neg <= w_dvd_neg;
            r_result  <= '0;
          end
        end
        c_st_by_zero: begin
          if (!dif.annul_i) begin
            r_result <= {r_dvd_raw, {c_div_width{1'b1}}};
          end
        end
        c_st_on: begin
          if (!dif.annul_i) begin
            r_rem <= w_rem_step;
            r_quo <= w_quo_step;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_result <= {w_rem_fix, w_quo_fix};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
